jk_cmd_driver: RTL and testbench
================================

# jk_cmd_driver

Command front-end for a bank of master-slave JK flip-flops. It accepts per-bit operation requests (hold, reset, set, toggle) over a valid/ready handshake and buffers them in a small FIFO. Each command is replayed as registered `j`/`k` pairs that are held stable across the downstream capturing edge, followed by a hold cycle. It also keeps a shadow copy of the expected flip-flop outputs for checking and status. The block sits directly upstream of the `MS_JK_ff` cells and drives their `j`/`k` inputs.

## Interface
- `WIDTH`, default 4: number of JK cells driven. Range 1–32.
- `DEPTH`, default 4: command FIFO entries. Must be a power of 2, ≥2.

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: a command is offered.
- `cmd_ready` output 1: the FIFO can accept a command. Equals `!full`.
- `cmd_op` input 2: operation, encoded as {j,k}. 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- `cmd_mask` input WIDTH: bits the operation applies to. Unmasked bits receive {j,k}=00.
- `j` output WIDTH: registered J drive to the JK cells.
- `k` output WIDTH: registered K drive to the JK cells.
- `q_shadow` output WIDTH: expected Q of the cells after every applied command.
- `busy` output 1: high when the FIFO is non-empty or the FSM is not IDLE.

## Operation
- A handshake occurs when `cmd_valid && cmd_ready` at a rising edge. {op, mask} is written to the FIFO. `cmd_valid` held with `cmd_ready` low is not an error; the command waits.
- The FSM has three states: IDLE, APPLY, SETTLE.
  - IDLE → APPLY when the FIFO is non-empty. The head entry is popped, and `j`/`k` are loaded with per-bit {j,k} = mask ? op : 00.
  - APPLY → SETTLE unconditionally. `j`/`k` are cleared to 0. `q_shadow` is updated per bit: 00 keep, 01 →0, 10 →1, 11 invert.
  - SETTLE → APPLY when the FIFO is non-empty, popping and loading as above. Otherwise SETTLE → IDLE.
- `j`/`k` are non-zero only while the FSM is in APPLY. They are always 0 in IDLE and SETTLE.
- A HOLD op still occupies one APPLY + SETTLE slot, with `j`=`k`=0.
- FIFO behaviour:
  - Push and pop in the same cycle are both allowed. Occupancy is unchanged.
  - When full, `cmd_ready` is 0 and no push occurs, even if a pop happens that cycle. `cmd_ready` rises the cycle after the pop.
  - Pointers wrap modulo DEPTH. Full/empty are distinguished with an extra pointer bit.
- Reset (asynchronous, any time, including mid-APPLY): FIFO empty, state IDLE, `j`=`k`=0, `q_shadow`=0, `busy`=0, `cmd_ready`=1. In-flight and queued commands are discarded.
- The downstream cells are not reset by `rst_n`. System software issues RESET with mask all-ones after reset so the cells match `q_shadow`.

## Timing
- A command accepted at edge E0 appears on `j`/`k` after edge E1 (with an empty FIFO and the FSM in IDLE). The cell master captures at E2, and the cell Q changes at the falling edge after E2. `q_shadow` updates at E2.
- Latency from accept to cell Q is 2 rising edges plus a half cycle.
- Sustained throughput is one command per 2 cycles. `j`/`k` are held for exactly one full clock period around each capturing edge.
- `busy` falls on the edge the FSM returns to IDLE with the FIFO empty.

## Structure
- Package `jk_pkg`:
  - `jk_op_t` enum: HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11.
  - `drv_state_t` enum: IDLE, APPLY, SETTLE.
  - Function `jk_next(q, op)` returning the next Q; shared with the bench model.
- Sub-module `jk_cmd_fifo`: synchronous FIFO parameterised on data width (2+WIDTH) and DEPTH, with async active-low reset, and `full`/`empty` outputs.
- Top level: FSM, the `j`/`k` output registers, and the `q_shadow` register.

## Test plan
- Reset release, then SET with mask 4'b1111 → `j`=4'hF, `k`=0 for exactly one cycle, 2 edges after accept. `q_shadow`=4'hF. The four `MS_JK_ff` cells read Q=1.
- Back-to-back TOGGLE mask 4'b0101, ×3 → `j`/`k` pulse every 2nd cycle. `q_shadow` goes 0101 → 0000 → 0101 (starting from 0000). Cell Q matches after each falling edge.
- Push 5 commands with DEPTH=4 while the FSM is stalled → `cmd_ready` is 0 after the 4th accept. The 5th is accepted the cycle after the first pop. All 5 are applied in order.
- Simultaneous push and pop with the FIFO holding 2 entries → occupancy stays 2, and order is preserved across pointer wrap (10 commands total).
- Assert `rst_n` low mid-APPLY with 3 entries queued → `j`=`k`=0 immediately (async), `busy`=0, `cmd_ready`=1, `q_shadow`=0. No queued command is replayed after release.
- HOLD with mask all-ones, then RESET with mask 4'b0010 → HOLD produces no `j`/`k` activity but takes a 2-cycle slot. RESET drives `k`=4'b0010 and clears bit 1 only.

Source files
------------

// File: rtl/jk_cmd_driver_pkg.sv
// Shared types and the per-bit JK next-state rule for the JK command driver.
// The bench model uses these types as well.
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_t;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SETTLE
    } drv_state_t;

    // Next Q of one master-slave JK cell given its current Q and the {j,k} pair.
    function automatic logic jk_next(input logic q, input jk_op_t op);
        case (op)
            HOLD:    return q;
            RESET:   return 1'b0;
            SET:     return 1'b1;
            default: return ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_cmd_driver_if.sv
// Valid/ready command bus carrying a JK operation and the per-cell mask it applies to.
interface jk_cmd_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;

    modport master (output cmd_valid, output cmd_op, output cmd_mask, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_mask, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; an extra pointer bit separates the full case from the empty case.
// A push is refused while full, even when a pop happens in the same cycle.
module jk_cmd_fifo #(
    parameter int DW    = 6,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/jk_cmd_driver.sv
// Replays queued JK commands as one-cycle j/k pulses, each followed by a settle cycle,
// and tracks the Q the downstream cells should hold after each command.
module jk_cmd_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_cmd_if.slave          cmd,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q_shadow,
    output logic             busy
);
    drv_state_t       state;
    logic [WIDTH+1:0] head;
    logic [1:0]       head_op;
    logic [WIDTH-1:0] head_mask;
    logic             full;
    logic             empty;
    logic             pop;
    logic [WIDTH-1:0] q_next;

    jk_cmd_fifo #(
        .DW    (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cmd.cmd_valid),
        .wr_data ({cmd.cmd_op, cmd.cmd_mask}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign cmd.cmd_ready = !full;
    assign head_op       = head[WIDTH+1:WIDTH];
    assign head_mask     = head[WIDTH-1:0];
    assign pop           = (state != APPLY) && !empty;
    assign busy          = !empty || (state != IDLE);

    // The pulse being applied is exactly what the cells capture, so Q follows from j/k.
    always_comb begin
        q_next = q_shadow;
        for (int i = 0; i < WIDTH; i++) begin
            q_next[i] = jk_next(q_shadow[i], jk_op_t'({j[i], k[i]}));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            j        <= '0;
            k        <= '0;
            q_shadow <= '0;
        end else begin
            case (state)
                IDLE, SETTLE: begin
                    if (!empty) begin
                        state <= APPLY;
                        j     <= head_mask & {WIDTH{head_op[1]}};
                        k     <= head_mask & {WIDTH{head_op[0]}};
                    end else begin
                        state <= IDLE;
                    end
                end
                APPLY: begin
                    state    <= SETTLE;
                    j        <= '0;
                    k        <= '0;
                    q_shadow <= q_next;
                end
                default: begin
                    state <= IDLE;
                    j     <= '0;
                    k     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Randomised bench for jk_cmd_driver against a queue-based timing model and a small
// behavioural model of the downstream master-slave JK cells.
module tb_jk_cmd_driver;
    import jk_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] qShadow;
    logic             busy;

    jk_cmd_if #(.WIDTH(WIDTH)) cmdIf ();

    jk_cmd_driver #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmdIf),
        .j        (j),
        .k        (k),
        .q_shadow (qShadow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Downstream cells: master captures on the rising edge, Q follows on the falling edge.
    logic [WIDTH-1:0] cellMaster;
    logic [WIDTH-1:0] cellQ;
    always @(posedge clk) cellMaster <= (j & ~cellQ) | (~k & cellQ);
    always @(negedge clk) cellQ <= cellMaster;

    cmd_t             modelQ[$];
    cmd_t             inFlight;
    int               edgesSinceStart;
    logic [WIDTH-1:0] modelQShadow;
    logic [WIDTH-1:0] modelJ;
    logic [WIDTH-1:0] modelK;
    bit               cellsSynced;
    int               checks = 0;
    int               errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        modelQ.delete();
        edgesSinceStart = 2;
        modelQShadow    = '0;
        modelJ          = '0;
        modelK          = '0;
        cellsSynced     = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] applyOp(input logic [WIDTH-1:0] q, input cmd_t c);
        case (c.op)
            RESET:   return q & ~c.mask;
            SET:     return q | c.mask;
            TOGGLE:  return q ^ c.mask;
            default: return q;
        endcase
    endfunction

    // One clock: drive, step the model at the rising edge, compare after the falling edge.
    task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                 input logic [WIDTH-1:0] mask, output bit accepted);
        bit startNow;
        cmdIf.cmd_valid = valid;
        cmdIf.cmd_op    = op;
        cmdIf.cmd_mask  = mask;
        @(posedge clk);
        startNow = (modelQ.size() > 0) && (edgesSinceStart >= 1);
        accepted = valid && (modelQ.size() < DEPTH);
        if (edgesSinceStart == 0) begin
            modelQShadow = applyOp(modelQShadow, inFlight);
            if (inFlight.op == RESET && inFlight.mask == ALL_ONES) cellsSynced = 1'b1;
        end
        modelJ = '0;
        modelK = '0;
        if (startNow) begin
            inFlight        = modelQ.pop_front();
            modelJ          = (inFlight.op == SET || inFlight.op == TOGGLE) ? inFlight.mask : '0;
            modelK          = (inFlight.op == RESET || inFlight.op == TOGGLE) ? inFlight.mask : '0;
            edgesSinceStart = 0;
        end else if (edgesSinceStart < 2) begin
            edgesSinceStart++;
        end
        if (accepted) modelQ.push_back(cmd_t'({op, mask}));
        @(negedge clk);
        #1;
        checkOutput("j", j, modelJ);
        checkOutput("k", k, modelK);
        checkOutput("q_shadow", qShadow, modelQShadow);
        checkOutput("busy", busy, (modelQ.size() > 0) || (edgesSinceStart < 2));
        checkOutput("cmd_ready", cmdIf.cmd_ready, modelQ.size() < DEPTH);
        if (cellsSynced) checkOutput("cell_q", cellQ, qShadow);
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [WIDTH-1:0] mask);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 20) begin
            applyStimulus(1'b1, op, mask, acc);
            n++;
        end
        checkOutput("accept", acc, 1'b1);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int c = 0; c < n; c++) applyStimulus(1'b0, 2'b00, '0, acc);
    endtask

    task automatic randomTraffic(input int cycles, input int validPct);
        bit   acc;
        bit   havePending = 1'b0;
        cmd_t pend = '0;
        for (int c = 0; c < cycles; c++) begin
            if (!havePending && $urandom_range(99) < validPct) begin
                pend        = cmd_t'($urandom);
                havePending = 1'b1;
            end
            applyStimulus(havePending, pend.op, pend.mask, acc);
            if (acc) havePending = 1'b0;
        end
    endtask

    initial begin
        bit   acc;
        bit   reached;
        cmd_t pend;
        cmdIf.cmd_valid = 1'b0;
        cmdIf.cmd_op    = 2'b00;
        cmdIf.cmd_mask  = '0;
        rst_n           = 1'b1;
        resetModel();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_j", j, '0);
        checkOutput("reset_k", k, '0);
        checkOutput("reset_q_shadow", qShadow, '0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_cmd_ready", cmdIf.cmd_ready, 1'b1);
        rst_n = 1'b1;

        sendCmd(RESET, ALL_ONES);
        idleCycles(4);
        sendCmd(SET, ALL_ONES);
        idleCycles(4);
        sendCmd(RESET, ALL_ONES);
        for (int n = 0; n < 3; n++) sendCmd(TOGGLE, 4'b0101);
        idleCycles(8);
        sendCmd(HOLD, ALL_ONES);
        sendCmd(RESET, 4'b0010);
        idleCycles(6);

        $display("[TB] burst fill and pointer wrap");
        for (int n = 0; n < 10; n++) sendCmd(2'($urandom), WIDTH'($urandom));
        idleCycles(24);
        randomTraffic(400, 70);
        idleCycles(24);

        $display("[TB] reset during APPLY with a backlog");
        reached = 1'b0;
        for (int c = 0; c < 60 && !reached; c++) begin
            pend = cmd_t'($urandom);
            applyStimulus(1'b1, pend.op, pend.mask, acc);
            reached = (edgesSinceStart == 0) && (modelQ.size() >= 3);
        end
        checkOutput("mid_apply_reached", reached, 1'b1);
        cmdIf.cmd_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_j", j, '0);
        checkOutput("async_k", k, '0);
        checkOutput("async_busy", busy, 1'b0);
        checkOutput("async_cmd_ready", cmdIf.cmd_ready, 1'b1);
        checkOutput("async_q_shadow", qShadow, '0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idleCycles(8);

        sendCmd(RESET, ALL_ONES);
        randomTraffic(200, 50);
        idleCycles(24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
